cnn_frame_sequencer: RTL and testbench
======================================

Name: cnn_frame_sequencer

Overview:
- Frame-level controller for the image BRAM → padding → conv → pool datapath. Replaces the free-running clock divider and scan counter.
- On a start request, walks the padded image raster at a programmable pixel cadence and drives the BRAM address/enable. It flags pad positions and emits a read-latency-aligned valid strobe for the downstream stages.
- Honours a downstream ready (stall) input and reports busy/frame_done around the whole frame, including pipeline drain.

Parameters:
IMG_W, 64, image width in pixels (interior)
IMG_H, 64, image height in pixels (interior)
PAD, 1, padding border width on every side (0..3)
DIV, 4, clock cycles per issued pixel (1..15)
RD_LAT, 2, BRAM read latency in cycles (1..4)
TAIL, 4, extra drain cycles for conv/pool pipeline after the last read returns

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  frame request; sampled only in IDLE
ready  in  1  downstream can accept; 0 freezes the scan
busy  out  1  frame in progress
frame_done  out  1  one-cycle pulse at end of frame
i  out  7  current padded row, 0..IMG_H+2*PAD-1
j  out  7  current padded column, 0..IMG_W+2*PAD-1
addr  out  13  BRAM address, (i-PAD)*IMG_W+(j-PAD); 0 on pad positions
mem_en  out  1  BRAM enable; high in an issue cycle on an interior position only
issue  out  1  one-cycle pulse: i/j/addr/mem_en describe a new position
pad_flag  out  1  current position lies in the pad border
pix_valid  out  1  issue delayed by RD_LAT; BRAM data (or pad zero) valid for downstream
pix_pad  out  1  pad_flag delayed by RD_LAT, aligned with pix_valid

Behaviour:
- Reset (synchronous, has priority over everything):
  - State goes to IDLE. All outputs are 0, the delay lines are cleared, and the position is (0,0).
  - Reset mid-frame abandons the frame with no frame_done pulse.
- All outputs are registered.
- States:
  - IDLE → SCAN on the edge where start=1.
  - SCAN → DRAIN after the last position has been issued.
  - DRAIN → DONE after the drain count expires.
  - DONE → IDLE unconditionally after one cycle.
- IDLE:
  - busy=0 and issue=0; start is sampled.
  - On the start edge, position (0,0) is issued, so issue=1 in the following cycle, and the divider is cleared.
- SCAN:
  - The divider counts 0..DIV-1 on every cycle with ready=1.
  - On the edge where the divider is at DIV-1 and ready=1, the position advances: j+1, wrapping to 0 with i+1 at the row end, and the next issue pulse follows.
  - ready=0 freezes the divider and the position. An issue pulse already registered is still delivered, and the delay lines keep shifting.
  - Issues are therefore spaced exactly DIV cycles apart when ready stays high. DIV=1 gives an issue every cycle.
- Pad test: pad_flag=1 iff i<PAD, i>=IMG_H+PAD, j<PAD or j>=IMG_W+PAD. Pad positions give mem_en=0 and addr=0.
- Raster order is row-major. The last position is (IMG_H+2*PAD-1, IMG_W+2*PAD-1). The position does not wrap past the last one.
- Delay line: pix_valid and pix_pad equal issue and pad_flag exactly RD_LAT cycles earlier, independent of ready.
- Drain and completion:
  - frame_done pulses exactly RD_LAT+TAIL cycles after the last issue cycle (the DONE state).
  - busy is high from the cycle after the start edge through the frame_done cycle inclusive.
- start while busy is ignored; there is no queuing.
- start held high across DONE→IDLE launches a new frame on the IDLE cycle.
- Address arithmetic uses an unsigned multiply-add, 13-bit result. The default 64x64 maximum is 4095.

Test Plan:
- IMG_W=4, IMG_H=3, PAD=1, DIV=2, RD_LAT=2, TAIL=4; start high at cycle 0 → 30 issues, at cycles 1,3,…,59:
  - the first at (0,0) with pad_flag=1 and mem_en=0;
  - (1,1) gives addr=0, mem_en=1; (3,4) gives addr=11;
  - pix_valid at cycles 3,…,61; frame_done only at cycle 65; busy high for cycles 1–65.
- Same configuration, ready=0 for cycles 10–14 → issue schedule after cycle 9 shifted by 5 cycles; frame_done at cycle 70; no position skipped or repeated (30 issues, 12 with mem_en=1).
- Defaults (64x64, PAD=1, DIV=4) → 4356 issues; 4096 with mem_en=1; addr sequence 0..4095 monotonic, each value once; pad count 260.
- rst asserted at cycle 20 of a running frame → next cycle busy=0, all outputs 0, no frame_done; a new start runs a full normal frame.
- start pulsed at cycle 30 while busy → ignored; exactly one frame_done. Then start held high continuously → back-to-back frames, the next beginning on the IDLE cycle after DONE.
- DIV=1, RD_LAT=1, PAD=0, IMG_W=IMG_H=2 → issues on 4 consecutive cycles; all mem_en=1; addr 0,1,2,3; pix_valid one cycle later; pad_flag never set.

Source files
------------

// File: rtl/cnn_frame_sequencer_if.sv
// Handshake and scan bundle between the frame sequencer and its host/datapath.
// The slave side is the sequencer; the master side requests frames and consumes the scan.
interface cnn_frame_sequencer_if;
  logic        start;
  logic        ready;
  logic        busy;
  logic        frame_done;
  logic [6:0]  i;
  logic [6:0]  j;
  logic [12:0] addr;
  logic        mem_en;
  logic        issue;
  logic        pad_flag;
  logic        pix_valid;
  logic        pix_pad;

  modport slave (
    input  start, ready,
    output busy, frame_done, i, j, addr, mem_en,
    output issue, pad_flag, pix_valid, pix_pad
  );

  modport master (
    output start, ready,
    input  busy, frame_done, i, j, addr, mem_en,
    input  issue, pad_flag, pix_valid, pix_pad
  );
endinterface

// File: rtl/cnn_frame_sequencer.sv
// Frame-level scan controller: walks the padded raster at a fixed pixel cadence,
// drives BRAM address/enable and emits read-latency-aligned valid/pad strobes.
module cnn_frame_sequencer #(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int PAD    = 1,
  parameter int DIV    = 4,
  parameter int RD_LAT = 2,
  parameter int TAIL   = 4
) (
  input logic                  i_clk,
  input logic                  i_rst,
  cnn_frame_sequencer_if.slave bus
);

  localparam logic [6:0]  LAST_I   = 7'(IMG_H + 2 * PAD - 1);
  localparam logic [6:0]  LAST_J   = 7'(IMG_W + 2 * PAD - 1);
  localparam logic [6:0]  PAD7     = 7'(PAD);
  localparam logic [6:0]  IMG_H7   = 7'(IMG_H);
  localparam logic [6:0]  IMG_W7   = 7'(IMG_W);
  localparam logic [3:0]  DIV_M1   = 4'(DIV - 1);
  localparam int          DRAIN_N  = RD_LAT + TAIL - 1;
  localparam logic [15:0] DRAIN_LD = 16'((DRAIN_N > 0) ? DRAIN_N - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [3:0]          r_div;
  logic [15:0]         r_cnt;
  logic [6:0]          r_i;
  logic [6:0]          r_j;
  logic [12:0]         r_addr;
  logic                r_busy;
  logic                r_done;
  logic                r_issue;
  logic                r_mem_en;
  logic                r_pad;
  logic [RD_LAT-1:0]   r_vsr;
  logic [RD_LAT-1:0]   r_psr;

  logic                w_last;
  logic                w_wrap;
  logic [6:0]          w_ni;
  logic [6:0]          w_nj;
  logic [6:0]          w_ri;
  logic [6:0]          w_ci;
  logic                w_npad;
  logic [12:0]         w_naddr;

  // Interior offsets wrap to large values above the pad, so one
  // unsigned compare per axis classifies both borders.
  always_comb begin
    w_last  = (r_i == LAST_I) && (r_j == LAST_J);
    w_wrap  = (r_j == LAST_J);
    w_ni    = w_wrap ? r_i + 7'd1 : r_i;
    w_nj    = w_wrap ? 7'd0 : r_j + 7'd1;
    w_ri    = w_ni - PAD7;
    w_ci    = w_nj - PAD7;
    w_npad  = !((w_ri < IMG_H7) && (w_ci < IMG_W7));
    w_naddr = 13'd0;
    if (!w_npad) begin
      w_naddr = 13'(w_ri) * 13'(IMG_W) + 13'(w_ci);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_div    <= '0;
      r_cnt    <= '0;
      r_i      <= '0;
      r_j      <= '0;
      r_addr   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_issue  <= 1'b0;
      r_mem_en <= 1'b0;
      r_pad    <= 1'b0;
      r_vsr    <= '0;
      r_psr    <= '0;
    end else begin
      r_issue  <= 1'b0;
      r_mem_en <= 1'b0;
      r_done   <= 1'b0;
      r_vsr[0] <= r_issue;
      r_psr[0] <= r_pad;
      for (int k = 1; k < RD_LAT; k++) begin
        r_vsr[k] <= r_vsr[k-1];
        r_psr[k] <= r_psr[k-1];
      end
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state  <= S_SCAN;
            r_busy   <= 1'b1;
            r_div    <= '0;
            r_i      <= '0;
            r_j      <= '0;
            r_addr   <= '0;
            r_issue  <= 1'b1;
            r_pad    <= (PAD != 0);
            r_mem_en <= (PAD == 0);
          end
        end
        S_SCAN: begin
          // Last position already issued this cycle; stall cannot hold it.
          if (w_last) begin
            if (DRAIN_N == 0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_DRAIN;
              r_cnt   <= DRAIN_LD;
            end
          end else if (bus.ready) begin
            if (r_div == DIV_M1) begin
              r_div    <= '0;
              r_i      <= w_ni;
              r_j      <= w_nj;
              r_addr   <= w_naddr;
              r_pad    <= w_npad;
              r_issue  <= 1'b1;
              r_mem_en <= !w_npad;
            end else begin
              r_div <= r_div + 4'd1;
            end
          end
        end
        S_DRAIN: begin
          if (r_cnt == 16'd0) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy       = r_busy;
  assign bus.frame_done = r_done;
  assign bus.i          = r_i;
  assign bus.j          = r_j;
  assign bus.addr       = r_addr;
  assign bus.mem_en     = r_mem_en;
  assign bus.issue      = r_issue;
  assign bus.pad_flag   = r_pad;
  assign bus.pix_valid  = r_vsr[RD_LAT-1];
  assign bus.pix_pad    = r_psr[RD_LAT-1];

endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// Bench for cnn_frame_sequencer: small, default and minimal configurations
// checked against a cycle-level scan model built from the raster rules.
module tb_cnn_frame_sequencer;

  localparam int AW  = 4;
  localparam int AH  = 3;
  localparam int AP  = 1;
  localparam int AD  = 2;
  localparam int AR  = 2;
  localparam int AT  = 4;
  localparam int AWP = AW + 2 * AP;
  localparam int AHP = AH + 2 * AP;
  localparam int ANP = AWP * AHP;
  localparam int N   = 280;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, rst_c;

  cnn_frame_sequencer_if a_if ();
  cnn_frame_sequencer_if b_if ();
  cnn_frame_sequencer_if c_if ();

  cnn_frame_sequencer #(
    .IMG_W(AW), .IMG_H(AH), .PAD(AP), .DIV(AD), .RD_LAT(AR), .TAIL(AT)
  ) u_a (.i_clk(clk), .i_rst(rst_a), .bus(a_if));

  cnn_frame_sequencer u_b (.i_clk(clk), .i_rst(rst_b), .bus(b_if));

  cnn_frame_sequencer #(
    .IMG_W(2), .IMG_H(2), .PAD(0), .DIV(1), .RD_LAT(1), .TAIL(4)
  ) u_c (.i_clk(clk), .i_rst(rst_c), .bus(c_if));

  int errors = 0;
  int checks = 0;

  bit          in_start[N];
  bit          in_ready[N];
  bit          in_rst[N];
  logic [33:0] o_vec[N];

  bit e_issue[N];
  bit e_done[N];
  bit e_busy[N];
  int e_idx[N];
  int rst_at;

  function automatic bit pad_of(int k);
    int r, c;
    r = k / AWP;
    c = k % AWP;
    return (r < AP) || (r >= AH + AP) || (c < AP) || (c >= AW + AP);
  endfunction

  function automatic logic [12:0] addr_of(int k);
    if (pad_of(k)) return 13'd0;
    return 13'((k / AWP - AP) * AW + (k % AWP - AP));
  endfunction

  function automatic logic [33:0] exp_vec(int c);
    logic [6:0]  ei, ej;
    logic [12:0] ea;
    bit          ep, pv, pp, men;
    int          cc, seg;
    ei = '0; ej = '0; ea = '0; ep = 0; pv = 0; pp = 0;
    if (e_idx[c] >= 0) begin
      ei = 7'(e_idx[c] / AWP);
      ej = 7'(e_idx[c] % AWP);
      ea = addr_of(e_idx[c]);
      ep = pad_of(e_idx[c]);
    end
    cc  = c - AR;
    seg = (c >= rst_at) ? rst_at : 0;
    if (cc >= seg) begin
      pv = e_issue[cc];
      pp = (e_idx[cc] >= 0) && pad_of(e_idx[cc]);
    end
    men = e_issue[c] && !ep;
    return {e_issue[c], ei, ej, ea, men, ep, pv, pp, e_done[c], e_busy[c]};
  endfunction

  task automatic clear_model;
    for (int c = 0; c < N; c++) begin
      e_issue[c] = 0; e_done[c] = 0; e_busy[c] = 0; e_idx[c] = -1;
      in_start[c] = 0; in_ready[c] = 1; in_rst[c] = 0;
    end
    rst_at = N + 1;
  endtask

  // One frame launched by a start sampled at cycle s: a new position
  // follows the cycle in which DIV ready cycles have been seen.
  task automatic build_frame(input int s, output int done);
    int t, cnt, q;
    t = s + 1;
    for (int k = 0; k < ANP; k++) begin
      if (t >= N) break;
      e_issue[t] = 1;
      for (int c = t; c < N; c++) e_idx[c] = k;
      if (k < ANP - 1) begin
        cnt = 0;
        q = t;
        while (q < N) begin
          if (in_ready[q]) cnt++;
          if (cnt == AD) break;
          q++;
        end
        t = q + 1;
      end
    end
    done = t + AR + AT;
    for (int c = s + 1; c <= done && c < N; c++) e_busy[c] = 1;
    if (done < N) e_done[done] = 1;
  endtask

  task automatic run_a(input int n);
    rst_a = 1; a_if.start = 0; a_if.ready = 1;
    @(negedge clk);
    @(negedge clk);
    rst_a = 0;
    for (int c = 0; c < n; c++) begin
      o_vec[c] = {a_if.issue, a_if.i, a_if.j, a_if.addr, a_if.mem_en,
                  a_if.pad_flag, a_if.pix_valid, a_if.pix_pad,
                  a_if.frame_done, a_if.busy};
      a_if.start = in_start[c];
      a_if.ready = in_ready[c];
      rst_a      = in_rst[c];
      @(negedge clk);
    end
  endtask

  task automatic tally(input int n, output int n_iss, output int n_men,
                       output int n_done, output int first_done);
    n_iss = 0; n_men = 0; n_done = 0; first_done = -1;
    for (int c = 0; c < n; c++) begin
      n_iss += int'(o_vec[c][33]);
      n_men += int'(o_vec[c][5]);
      if (o_vec[c][1]) begin
        n_done++;
        if (first_done < 0) first_done = c;
      end
    end
  endtask

  task automatic test_reset;
    clear_model();
    run_a(12);
    for (int c = 0; c < 12; c++) begin
      checks++;
      if (o_vec[c] !== exp_vec(c)) begin
        errors++;
        $display("FAIL reset c=%0d got %h exp %h", c, o_vec[c], exp_vec(c));
      end
    end
  endtask

  task automatic test_frame;
    int d, ni, nm, nd, fd;
    logic [12:0] a34;
    clear_model();
    in_start[0] = 1;
    build_frame(0, d);
    run_a(80);
    for (int c = 0; c < 80; c++) begin
      checks++;
      if (o_vec[c] !== exp_vec(c)) begin
        errors++;
        $display("FAIL frame c=%0d got %h exp %h", c, o_vec[c], exp_vec(c));
      end
    end
    tally(80, ni, nm, nd, fd);
    a34 = 13'h1fff;
    for (int c = 0; c < 80; c++)
      if (o_vec[c][33] && o_vec[c][32:26] == 7'd3 && o_vec[c][25:19] == 7'd4)
        a34 = o_vec[c][18:6];
    checks++;
    if (ni != 30) begin errors++; $display("FAIL frame_issues got %0d exp 30", ni); end
    checks++;
    if (nd != 1 || fd != 65) begin
      errors++; $display("FAIL frame_done got n=%0d at %0d exp 1 at 65", nd, fd);
    end
    checks++;
    if ({o_vec[1][33], o_vec[1][5], o_vec[1][4]} !== 3'b101) begin
      errors++; $display("FAIL first_issue got %b exp 101", {o_vec[1][33], o_vec[1][5], o_vec[1][4]});
    end
    checks++;
    if (a34 !== 13'd11) begin errors++; $display("FAIL addr_3_4 got %0d exp 11", a34); end
  endtask

  task automatic test_stall;
    int d, ni, nm, nd, fd;
    clear_model();
    in_start[0] = 1;
    for (int c = 10; c <= 14; c++) in_ready[c] = 0;
    build_frame(0, d);
    run_a(85);
    for (int c = 0; c < 85; c++) begin
      checks++;
      if (o_vec[c] !== exp_vec(c)) begin
        errors++;
        $display("FAIL stall c=%0d got %h exp %h", c, o_vec[c], exp_vec(c));
      end
    end
    tally(85, ni, nm, nd, fd);
    checks++;
    if (ni != 30 || nm != 12) begin
      errors++; $display("FAIL stall_counts got %0d/%0d exp 30/12", ni, nm);
    end
    checks++;
    if (fd != 70) begin errors++; $display("FAIL stall_done got %0d exp 70", fd); end
  endtask

  task automatic test_random_ready;
    int d, ni, nm, nd, fd;
    clear_model();
    for (int c = 0; c < N; c++) in_ready[c] = ($urandom % 4) != 0;
    in_start[2] = 1;
    build_frame(2, d);
    run_a(200);
    for (int c = 0; c < 200; c++) begin
      checks++;
      if (o_vec[c] !== exp_vec(c)) begin
        errors++;
        $display("FAIL rand_ready c=%0d got %h exp %h", c, o_vec[c], exp_vec(c));
      end
    end
    tally(200, ni, nm, nd, fd);
    checks++;
    if (ni != 30 || nm != 12 || nd != 1) begin
      errors++; $display("FAIL rand_counts got %0d/%0d/%0d exp 30/12/1", ni, nm, nd);
    end
  endtask

  task automatic test_reset_mid;
    int d, ni, nm, nd, fd;
    clear_model();
    in_start[0]  = 1;
    in_rst[20]   = 1;
    in_start[30] = 1;
    build_frame(0, d);
    for (int c = 21; c < N; c++) begin
      e_issue[c] = 0; e_done[c] = 0; e_busy[c] = 0; e_idx[c] = -1;
    end
    rst_at = 21;
    build_frame(30, d);
    run_a(100);
    for (int c = 0; c < 100; c++) begin
      checks++;
      if (o_vec[c] !== exp_vec(c)) begin
        errors++;
        $display("FAIL reset_mid c=%0d got %h exp %h", c, o_vec[c], exp_vec(c));
      end
    end
    tally(100, ni, nm, nd, fd);
    checks++;
    if (o_vec[21] !== 34'd0) begin
      errors++; $display("FAIL reset_mid_zero got %h exp 0", o_vec[21]);
    end
    checks++;
    if (nd != 1 || fd != 95) begin
      errors++; $display("FAIL reset_mid_done got n=%0d at %0d exp 1 at 95", nd, fd);
    end
  endtask

  task automatic test_back_to_back;
    int d, s, ni, nm, nd, fd;
    clear_model();
    in_start[0]  = 1;
    in_start[30] = 1;
    for (int c = 70; c < N; c++) in_start[c] = 1;
    build_frame(0, d);
    s = 70;
    while (s < N) begin
      build_frame(s, d);
      s = d + 1;
    end
    run_a(N);
    for (int c = 0; c < N; c++) begin
      checks++;
      if (o_vec[c] !== exp_vec(c)) begin
        errors++;
        $display("FAIL b2b c=%0d got %h exp %h", c, o_vec[c], exp_vec(c));
      end
    end
    tally(70, ni, nm, nd, fd);
    checks++;
    if (nd != 1 || ni != 30) begin
      errors++; $display("FAIL busy_start got done=%0d issues=%0d exp 1/30", nd, ni);
    end
    checks++;
    if ({o_vec[135][1], o_vec[136][0], o_vec[137][33]} !== 3'b101) begin
      errors++;
      $display("FAIL b2b_relaunch got %b exp 101",
               {o_vec[135][1], o_vec[136][0], o_vec[137][33]});
    end
  endtask

  task automatic test_defaults;
    int k, nin, nmen, npf, cyc, r, c;
    bit seen, p;
    k = 0; nin = 0; nmen = 0; npf = 0; cyc = 0; seen = 0;
    rst_b = 1; b_if.start = 0; b_if.ready = 1;
    @(negedge clk);
    @(negedge clk);
    rst_b = 0; b_if.start = 1;
    @(negedge clk);
    b_if.start = 0;
    while (cyc < 40000 && !seen) begin
      b_if.ready = ($urandom % 8) != 0;
      if (b_if.issue) begin
        r = k / 66;
        c = k % 66;
        p = (r < 1) || (r > 64) || (c < 1) || (c > 64);
        checks++;
        if ({b_if.i, b_if.j, b_if.pad_flag} !== {7'(r), 7'(c), p}) begin
          errors++;
          $display("FAIL def_pos k=%0d got %0d,%0d,%b exp %0d,%0d,%b",
                   k, b_if.i, b_if.j, b_if.pad_flag, r, c, p);
        end
        if (!p) begin
          checks++;
          if ({b_if.addr, b_if.mem_en} !== {13'(nin), 1'b1}) begin
            errors++;
            $display("FAIL def_addr k=%0d got %0d en=%b exp %0d en=1",
                     k, b_if.addr, b_if.mem_en, nin);
          end
          nin++;
        end
        nmen += int'(b_if.mem_en);
        npf  += int'(b_if.pad_flag);
        k++;
      end
      if (b_if.frame_done) seen = 1;
      cyc++;
      @(negedge clk);
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL def_timeout got no frame_done exp done"); end
    checks++;
    if (k != 4356 || nmen != 4096 || npf != 260) begin
      errors++;
      $display("FAIL def_counts got %0d/%0d/%0d exp 4356/4096/260", k, nmen, npf);
    end
  endtask

  task automatic test_tiny;
    logic [4:0]  ob, eb;
    logic [27:0] op, ep;
    rst_c = 1; c_if.start = 0; c_if.ready = 1;
    @(negedge clk);
    @(negedge clk);
    rst_c = 0;
    for (int c = 0; c < 14; c++) begin
      ob = {c_if.issue, c_if.pix_valid, c_if.pad_flag, c_if.pix_pad, c_if.frame_done};
      eb = {(c >= 1 && c <= 4), (c >= 2 && c <= 5), 1'b0, 1'b0, (c == 9)};
      checks++;
      if (ob !== eb) begin
        errors++; $display("FAIL tiny c=%0d got %b exp %b", c, ob, eb);
      end
      if (c_if.issue) begin
        op = {c_if.i, c_if.j, c_if.addr, c_if.mem_en};
        ep = {7'((c - 1) / 2), 7'((c - 1) % 2), 13'(c - 1), 1'b1};
        checks++;
        if (op !== ep) begin
          errors++; $display("FAIL tiny_pos c=%0d got %h exp %h", c, op, ep);
        end
      end
      c_if.start = (c == 0);
      @(negedge clk);
    end
  endtask

  initial begin
    rst_a = 1; rst_b = 1; rst_c = 1;
    a_if.start = 0; a_if.ready = 1;
    b_if.start = 0; b_if.ready = 1;
    c_if.start = 0; c_if.ready = 1;
    test_reset();
    test_frame();
    test_stall();
    test_random_ready();
    test_reset_mid();
    test_back_to_back();
    test_tiny();
    test_defaults();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
